tt_mux_ctrl: RTL
================

TT_MUX_CTRL -- requirements
Module: tt_mux_ctrl

Interface
REQ-001 Parameter NPROJ, default 12: number of attached project wrappers, range 1..16.
REQ-002 Parameter RST_CYCLES, default 8: cycles the selected project is held in reset after a switch, range 1..255.
REQ-003 clk  input  1  block clock; also the project clock source.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sel_valid  input  1  request to select project sel_addr.
REQ-006 sel_addr  input  4  project index requested.
REQ-007 sel_ready  output  1  request accepted when sel_valid and sel_ready are both high at a rising clk edge.
REQ-008 busy  output  1  high while a switch sequence is in progress (DRAIN or PRST).
REQ-009 cur_addr  output  4  last accepted address.
REQ-010 pad_ui_in  input  8  chip dedicated inputs.
REQ-011 pad_uio_in  input  8  chip bidirectional inputs.
REQ-012 pad_rst_n  input  1  chip-level project reset, active-low.
REQ-013 iw  output  18  broadcast wrapper input bundle {uio_in[7:0], ui_in[7:0], rst_n, clk}, MSB first.
REQ-014 ena  output  NPROJ  one enable per wrapper, at most one bit high.
REQ-015 ow_bus  input  NPROJ*24  concatenated wrapper outputs; slice p = ow_bus[24p+23:24p] = {uio_oe, uio_out, uo_out}.
REQ-016 pad_uo_out, pad_uio_out, pad_uio_oe  output  8 each  selected project outputs to pads.

Function
REQ-017 States IDLE (nothing selected), DRAIN, PRST, ACTIVE.
REQ-018 sel_ready SHALL be 1 in IDLE and ACTIVE, 0 in DRAIN and PRST; requests during DRAIN/PRST are not captured and must be held by the requester.
REQ-019 On acceptance at edge k: cur_addr <= sel_addr; state <= DRAIN at edge k, whether the address is new, identical to the current one, or out of range.
REQ-020 DRAIN lasts exactly 2 cycles with ena all zero; then PRST if cur_addr < NPROJ, else IDLE.
REQ-021 PRST lasts exactly RST_CYCLES cycles: ena[cur_addr]=1, iw[1]=0; then ACTIVE.
REQ-022 ACTIVE: ena[cur_addr]=1; iw[1]=pad_rst_n; persists until the next accepted request.
REQ-023 ena, busy, sel_ready and the internal project-reset SHALL be registered outputs of the state machine, glitch-free.
REQ-024 iw[0]=clk, passed through combinationally in all states.
REQ-025 iw[17:2]={pad_uio_in, pad_ui_in} in PRST and ACTIVE; all zero in IDLE and DRAIN.
REQ-026 iw[1]=0 in IDLE, DRAIN and PRST.
REQ-027 Pad outputs SHALL be registered, with 1-cycle latency from ow_bus slice cur_addr while in ACTIVE; they SHALL be zero the cycle after leaving ACTIVE and throughout IDLE, DRAIN and PRST.
REQ-028 pad_uio_oe=0 outside ACTIVE, so no pad is driven during a switch.
REQ-029 PRST counter: 8-bit; loaded with RST_CYCLES-1 on entry; decrements to 0; exits on 0; no wrap.
REQ-030 sel_addr >= NPROJ is accepted and leads to IDLE through DRAIN; cur_addr reports the requested value.
REQ-031 Changes on pad_rst_n while in PRST SHALL have no effect; iw[1] stays 0.

Reset
REQ-032 rst_n low: immediately state=IDLE; ena=0; cur_addr=0; busy=0; sel_ready=1; counter=0; iw[17:1]=0; all pad outputs=0.
REQ-033 rst_n low during DRAIN, PRST or ACTIVE: same values as REQ-032, asynchronously; the sequence is abandoned.
REQ-034 After rst_n rises, the first request is accepted at the first rising edge with sel_valid=1.

Verification
REQ-035 Reset, then sel_addr=3 pulsed for 1 cycle -> busy for 2+8 cycles; ena=0 for 2 cycles; ena=0x008 with iw[1]=0 for 8 cycles; then ACTIVE with iw[1]=pad_rst_n.
REQ-036 ACTIVE on project 3 with ow_bus slice 3=0xFF_A5_3C -> pad_uio_oe=0xFF, pad_uio_out=0xA5, pad_uo_out=0x3C one cycle later; other slices ignored.
REQ-037 ACTIVE on 3, request 3 again -> full DRAIN/PRST sequence is repeated; pad_uio_oe=0 throughout.
REQ-038 Request sel_addr=14 with NPROJ=12 -> 2 DRAIN cycles, then IDLE; ena=0; cur_addr=14; sel_ready=1.
REQ-039 sel_valid held high with sel_addr=5 during PRST of project 3 -> not accepted until ACTIVE; then switches to 5; ena never has 2 bits set.
REQ-040 rst_n asserted in the 4th PRST cycle -> ena=0, iw[1]=0, outputs zero with no clock edge; IDLE after release.

Source files
------------

// File: rtl/tt_mux_ctrl.sv
// Project multiplexer controller: selects one of NPROJ wrappers, drains, holds it in reset,
// then routes pads to it. All controls towards the wrappers come from flops.
module tt_mux_ctrl #(
    parameter int NPROJ      = 12,
    parameter int RST_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_valid,
    input  logic [3:0]         sel_addr,
    output logic               sel_ready,
    output logic               busy,
    output logic [3:0]         cur_addr,
    input  logic [7:0]         pad_ui_in,
    input  logic [7:0]         pad_uio_in,
    input  logic               pad_rst_n,
    output logic [17:0]        iw,
    output logic [NPROJ-1:0]   ena,
    input  logic [NPROJ*24-1:0] ow_bus,
    output logic [7:0]         pad_uo_out,
    output logic [7:0]         pad_uio_out,
    output logic [7:0]         pad_uio_oe,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {IDLE, DRAIN, PRST, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             drain_cnt, drain_nxt;
    logic [3:0]       cur_nxt;
    logic [NPROJ-1:0] ena_nxt;
    logic             live_q, act_q;
    logic             live_nxt;
    logic [23:0]      sel_slice;

    // Handshake: a request transfers on a rising edge where sel_valid and sel_ready are
    // both high; while sel_ready is low the requester must keep sel_valid/sel_addr stable.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drain_nxt = drain_cnt;
        cur_nxt   = cur_addr;
        case (state)
            IDLE, ACTIVE: begin
                if (sel_valid && sel_ready) begin
                    state_nxt = DRAIN;
                    cur_nxt   = sel_addr;
                    drain_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    if (int'(cur_addr) < NPROJ) begin
                        state_nxt = PRST;
                        cnt_nxt   = 8'(RST_CYCLES - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drain_nxt = 1'b1;
                end
            end
            PRST: begin
                if (cnt == 8'd0) state_nxt = ACTIVE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wrapper-facing controls are decoded from the next state so they leave a flop directly.
    always_comb begin
        live_nxt = (state_nxt == PRST) || (state_nxt == ACTIVE);
        ena_nxt  = '0;
        for (int i = 0; i < NPROJ; i++) begin
            ena_nxt[i] = live_nxt && (cur_nxt == 4'(i));
        end
        sel_slice = '0;
        for (int p = 0; p < NPROJ; p++) begin
            if (cur_addr == 4'(p)) sel_slice = ow_bus[24*p +: 24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            drain_cnt   <= 1'b0;
            cur_addr    <= 4'd0;
            ena         <= '0;
            busy        <= 1'b0;
            sel_ready   <= 1'b1;
            live_q      <= 1'b0;
            act_q       <= 1'b0;
            pad_uo_out  <= 8'd0;
            pad_uio_out <= 8'd0;
            pad_uio_oe  <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            drain_cnt   <= drain_nxt;
            cur_addr    <= cur_nxt;
            ena         <= ena_nxt;
            busy        <= (state_nxt == DRAIN) || (state_nxt == PRST);
            sel_ready   <= (state_nxt == IDLE) || (state_nxt == ACTIVE);
            live_q      <= live_nxt;
            act_q       <= (state_nxt == ACTIVE);
            if (state_nxt == ACTIVE) begin
                {pad_uio_oe, pad_uio_out, pad_uo_out} <= sel_slice;
            end else begin
                {pad_uio_oe, pad_uio_out, pad_uo_out} <= 24'd0;
            end
        end
    end

    assign iw        = {(live_q ? {pad_uio_in, pad_ui_in} : 16'd0), act_q & pad_rst_n, clk};
    assign state_dbg = state;

endmodule
